// File: rtl/synaptic_accumulator.sv
// Synaptic current accumulator.
// For each accepted spike from neuron src, the block walks every target
// neuron tgt, fetches weight(src, tgt) from an external synchronous
// weight memory and adds it, with Q9.8 saturation, into acc[tgt].
// Each target takes two cycles: RD presents the address and ACC consumes
// the weight returned one cycle later.
module synaptic_accumulator #(
    parameter int N_NEURONS = 16,
    parameter int ID_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spk_valid,
    input  logic [ID_W-1:0]     spk_id,
    output logic                spk_ready,
    output logic [2*ID_W-1:0]   w_addr,
    input  logic [16:0]         w_data,
    input  logic                step_clear,
    input  logic [ID_W-1:0]     i_rd_addr,
    output logic [16:0]         i_rd_data,
    output logic                busy,
    output logic                spk_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACC  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] LAST_TGT = ID_W'(N_NEURONS - 1);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] src;
    logic [ID_W-1:0] tgt;
    logic [ID_W-1:0] tgt_inc;
    logic            accept;
    logic            last_tgt;
    logic [16:0]     acc [N_NEURONS];
    logic [16:0]     acc_sel;
    logic [17:0]     sum;
    logic [16:0]     sum_sat;

    // Handshake, status outputs and next-state selection.
    // A step_clear overrides everything: no acceptance, no completion,
    // and the FSM is forced back to IDLE.
    always_comb begin
        spk_ready  = 1'b0;
        accept     = 1'b0;
        busy       = 1'b0;
        spk_done   = 1'b0;
        last_tgt   = (tgt == LAST_TGT);
        tgt_inc    = tgt + ID_W'(1);
        state_next = state;

        spk_ready = (state == IDLE) && !step_clear;
        accept    = spk_valid && spk_ready;
        busy      = (state != IDLE);

        if (step_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = RD;
                    end
                end
                RD: begin
                    state_next = ACC;
                end
                ACC: begin
                    if (last_tgt) begin
                        state_next = IDLE;
                        spk_done   = 1'b1;
                    end else begin
                        state_next = RD;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Spike context and weight address. The address is loaded on entry to
    // RD so it is already {src, tgt} throughout RD and then simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src    <= '0;
            tgt    <= '0;
            w_addr <= '0;
        end else if (!step_clear) begin
            if (accept) begin
                src    <= spk_id;
                tgt    <= '0;
                w_addr <= {spk_id, {ID_W{1'b0}}};
            end else if (state == ACC && !last_tgt) begin
                tgt    <= tgt_inc;
                w_addr <= {src, tgt_inc};
            end
        end
    end

    // Saturating Q9.8 add of the fetched weight onto the current target.
    // The 18-bit sum's top two bits differ only on overflow; 01 means it
    // overflowed upward, 10 downward.
    always_comb begin
        acc_sel = acc[tgt];
        sum     = {acc_sel[16], acc_sel} + {w_data[16], w_data};
        case (sum[17:16])
            2'b01:   sum_sat = 17'h0FFFF;
            2'b10:   sum_sat = 17'h10000;
            default: sum_sat = sum[16:0];
        endcase
    end

    // Accumulator bank: cleared by reset or step_clear, otherwise only the
    // current target is written, at the end of its ACC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                acc[i] <= '0;
            end
        end else if (step_clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                acc[i] <= '0;
            end
        end else if (state == ACC) begin
            acc[tgt] <= sum_sat;
        end
    end

    // Combinational read port; a same-cycle write is not yet visible.
    always_comb begin
        i_rd_data = acc[i_rd_addr];
    end

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Randomized self-checking bench for synaptic_accumulator.
// The reference model keeps one integer current per neuron and, for each
// spike, adds the whole weight row with clamping in plain arithmetic.
module tb_synaptic_accumulator;

    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk;
    logic            rst_n;
    logic            spk_valid;
    logic [IW-1:0]   spk_id;
    logic            spk_ready;
    logic [2*IW-1:0] w_addr;
    logic [16:0]     w_data;
    logic            step_clear;
    logic [IW-1:0]   i_rd_addr;
    logic [16:0]     i_rd_data;
    logic            busy;
    logic            spk_done;

    logic [16:0] mem [256];
    int          ref_acc [N];
    int          n_checks = 0;
    int          n_errors = 0;

    synaptic_accumulator #(.N_NEURONS(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spk_valid  (spk_valid),
        .spk_id     (spk_id),
        .spk_ready  (spk_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .step_clear (step_clear),
        .i_rd_addr  (i_rd_addr),
        .i_rd_data  (i_rd_data),
        .busy       (busy),
        .spk_done   (spk_done)
    );

    // Free-running clock, period 40.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Synchronous weight memory: data one cycle after the address.
    always @(posedge clk) begin
        w_data <= mem[w_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 65535)  return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    function automatic logic [16:0] to17(input int v);
        return v[16:0];
    endfunction

    function automatic int wt(input logic [IW-1:0] s, input logic [IW-1:0] t);
        return int'($signed(mem[{s, t}]));
    endfunction

    task automatic zero_model();
        for (int i = 0; i < N; i++) ref_acc[i] = 0;
    endtask

    task automatic fill_mem(input logic [16:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Mix of full-range weights (frequent saturation) and small ones.
    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            if ((i % 2) == 0) mem[i] = 17'($urandom);
            else              mem[i] = 17'(int'($urandom_range(0, 2047)) - 1024);
        end
    endtask

    // Reads every accumulator through the read port (uses 16 time units).
    task automatic compare_all(input string tag);
        for (int a = 0; a < N; a++) begin
            i_rd_addr = IW'(a);
            #1;
            check(tag, 32'(i_rd_data), 32'(to17(ref_acc[a])));
        end
    endtask

    // Offers a spike, follows it cycle by cycle until spk_done, then
    // updates the model and compares the whole accumulator bank.
    task automatic do_spike(input logic [IW-1:0] s);
        int            j;
        bit            done;
        logic [IW-1:0] t;
        spk_id    = s;
        spk_valid = 1'b1;
        #1;
        check("ready_before_accept", 32'(spk_ready), 32'd1);
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        j    = 1;
        done = 1'b0;
        while (!done && j <= 4 * N) begin
            t         = IW'((j - 1) / 2);
            i_rd_addr = t;
            @(negedge clk);
            check("busy_during_spike", 32'(busy), 32'd1);
            check("w_addr", 32'(w_addr), 32'({s, t}));
            check("pre_update_read", 32'(i_rd_data), 32'(to17(ref_acc[t])));
            if (spk_done) begin
                done = 1'b1;
                check("spk_done_latency", 32'(j), 32'(2 * N));
            end
            @(posedge clk);
            #1;
            j++;
        end
        if (!done) check("spk_done_timeout", 32'd0, 32'd1);
        for (int ti = 0; ti < N; ti++) begin
            ref_acc[ti] = clamp(ref_acc[ti] + wt(s, IW'(ti)));
        end
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(spk_done), 32'd0);
        check("idle_ready", 32'(spk_ready), 32'd1);
        compare_all("acc_after_spike");
        @(posedge clk);
        #1;
        $display("spike src=%0d done, acc[0]=%05h", s, to17(ref_acc[0]));
    endtask

    task automatic do_clear();
        step_clear = 1'b1;
        spk_valid  = 1'b0;
        @(negedge clk);
        check("clear_blocks_ready", 32'(spk_ready), 32'd0);
        @(posedge clk);
        #1;
        step_clear = 1'b0;
        zero_model();
        @(negedge clk);
        check("clear_busy", 32'(busy), 32'd0);
        compare_all("acc_after_clear");
        @(posedge clk);
        #1;
        $display("step_clear done");
    endtask

    initial begin
        rst_n      = 1'b0;
        spk_valid  = 1'b0;
        step_clear = 1'b0;
        spk_id     = '0;
        i_rd_addr  = '0;
        fill_mem(17'h0);
        zero_model();

        // Reset state, before any clock edge.
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(spk_done), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_ready", 32'(spk_ready), 32'd1);
        compare_all("rst_acc");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset released");

        // Uniform +1.5 row from neuron 3; first edge after reset accepts.
        fill_mem(17'h00180);
        do_spike(IW'(3));

        // Opposite weights onto neuron 7 cancel exactly.
        do_clear();
        fill_random();
        mem[{4'd3, 4'd7}] = 17'h00100;
        mem[{4'd5, 4'd7}] = 17'h1FF00;
        do_spike(IW'(3));
        do_spike(IW'(5));
        i_rd_addr = IW'(7);
        #1;
        check("acc7_cancel", 32'(i_rd_data), 32'h0);

        // Positive saturation, including a self-connection (src==tgt==2).
        do_clear();
        fill_mem(17'h0);
        mem[{4'd1, 4'd2}] = 17'h0FF00;
        mem[{4'd2, 4'd2}] = 17'h00200;
        do_spike(IW'(1));
        do_spike(IW'(2));
        i_rd_addr = IW'(2);
        #1;
        check("acc2_pos_sat", 32'(i_rd_data), 32'h0FFFF);

        // Negative saturation.
        do_clear();
        mem[{4'd1, 4'd2}] = 17'h10100;
        mem[{4'd2, 4'd2}] = 17'h1FE00;
        do_spike(IW'(1));
        do_spike(IW'(2));
        i_rd_addr = IW'(2);
        #1;
        check("acc2_neg_sat", 32'(i_rd_data), 32'h10000);

        // Random spikes against random weights.
        fill_random();
        repeat (8) do_spike(IW'($urandom_range(0, N - 1)));

        // step_clear at cycle 10 of a spike, with a new spike offered.
        spk_id    = IW'(6);
        spk_valid = 1'b1;
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        for (int j = 1; j < 10; j++) begin
            @(negedge clk);
            check("busy_before_clear", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        step_clear = 1'b1;
        spk_valid  = 1'b1;
        spk_id     = IW'(9);
        @(negedge clk);
        check("ready_during_clear", 32'(spk_ready), 32'd0);
        check("done_during_clear", 32'(spk_done), 32'd0);
        @(posedge clk);
        #1;
        step_clear = 1'b0;
        spk_valid  = 1'b0;
        zero_model();
        @(negedge clk);
        check("busy_after_clear", 32'(busy), 32'd0);
        compare_all("acc_mid_clear");
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            check("no_done_after_clear", 32'(spk_done), 32'd0);
            check("idle_after_clear", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        $display("mid-spike clear checked");

        // Asynchronous reset for half a cycle in the middle of a spike.
        do_spike(IW'(4));
        spk_id    = IW'(8);
        spk_valid = 1'b1;
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(spk_done), 32'd0);
        check("async_rst_w_addr", 32'(w_addr), 32'd0);
        zero_model();
        compare_all("async_rst_acc");
        #3;
        rst_n = 1'b1;
        $display("async reset pulse released");
        do_spike(IW'(8));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
